// File: rtl/sparse_dot_sequencer.sv
// Sparse dot-product sequencer: walks every (row, col) pair, merges the two sorted
// index lists and drives the shared FPU through MUL/ADD to accumulate each C[i][j].
module sparse_dot_sequencer #(
    parameter int  N_VEC   = 4,
    parameter int  MAX_NNZ = 4,
    parameter int  VAL_W   = 16,
    parameter int  IDX_W   = 16,
    localparam int VEC_AW  = $clog2(N_VEC),
    localparam int VEC_W   = 8 + (VAL_W + IDX_W) * MAX_NNZ
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              nnz_err,
    output logic [VEC_AW-1:0] a_addr,
    input  logic [VEC_W-1:0]  a_vec,
    output logic [VEC_AW-1:0] b_addr,
    input  logic [VEC_W-1:0]  b_vec,
    output logic              fpu_start,
    output logic              fpu_op,
    output logic [VAL_W-1:0]  fpu_a,
    output logic [VAL_W-1:0]  fpu_b,
    input  logic [VAL_W-1:0]  fpu_result,
    input  logic              fpu_complete,
    output logic              c_valid,
    output logic [VEC_AW-1:0] c_row,
    output logic [VEC_AW-1:0] c_col,
    output logic [VAL_W-1:0]  c_data
);
    localparam int PTR_W = $clog2(MAX_NNZ + 1);
    localparam int SEL_W = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
    localparam logic [VEC_AW-1:0] LAST = VEC_AW'(N_VEC - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, CMP, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, EMIT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [VEC_AW-1:0] row_i, col_j;
    logic [PTR_W-1:0]  pa, pb, nnz_a, nnz_b;
    logic [VAL_W-1:0]  val_a [MAX_NNZ];
    logic [VAL_W-1:0]  val_b [MAX_NNZ];
    logic [IDX_W-1:0]  idx_a [MAX_NNZ];
    logic [IDX_W-1:0]  idx_b [MAX_NNZ];
    logic [VAL_W-1:0]  acc;
    logic              acc_v;

    logic [SEL_W-1:0]  sel_a, sel_b;
    logic [IDX_W-1:0]  cur_idx_a, cur_idx_b;
    logic              end_cmp, hit;
    logic [1:0]        unused_size_lsb;

    // Size field counts value bytes: two per entry, bit 0 carries nothing.
    function automatic logic [PTR_W-1:0] clamp_nnz(input logic [6:0] n);
        if (n > 7'(MAX_NNZ))
            return PTR_W'(MAX_NNZ);
        return PTR_W'(n);
    endfunction

    function automatic logic over_nnz(input logic [6:0] n);
        return n > 7'(MAX_NNZ);
    endfunction

    assign unused_size_lsb = {a_vec[VEC_W-8], b_vec[VEC_W-8]};

    assign sel_a     = pa[SEL_W-1:0];
    assign sel_b     = pb[SEL_W-1:0];
    assign cur_idx_a = idx_a[sel_a];
    assign cur_idx_b = idx_b[sel_b];
    assign end_cmp   = (pa == nnz_a) || (pb == nnz_b);
    assign hit       = (cur_idx_a == cur_idx_b);

    assign a_addr    = row_i;
    assign b_addr    = col_j;
    assign c_row     = row_i;
    assign c_col     = col_j;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fpu_start = (state == MUL_REQ) || (state == ADD_REQ);
    assign c_valid   = (state == EMIT);
    assign c_data    = (state == EMIT && acc_v) ? acc : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     state_nxt = CMP;
            CMP: begin
                if (end_cmp)
                    state_nxt = EMIT;
                else if (hit)
                    state_nxt = MUL_REQ;
            end
            MUL_REQ:  state_nxt = MUL_WAIT;
            MUL_WAIT: if (fpu_complete) state_nxt = acc_v ? ADD_REQ : CMP;
            ADD_REQ:  state_nxt = ADD_WAIT;
            ADD_WAIT: if (fpu_complete) state_nxt = CMP;
            EMIT:     state_nxt = (row_i == LAST && col_j == LAST) ? DONE : LOAD;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Vector snapshot for the current pair; only meaningful after LOAD.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int k = 0; k < MAX_NNZ; k++) begin
                val_a[k] <= a_vec[IDX_W*MAX_NNZ + (MAX_NNZ-1-k)*VAL_W +: VAL_W];
                val_b[k] <= b_vec[IDX_W*MAX_NNZ + (MAX_NNZ-1-k)*VAL_W +: VAL_W];
                idx_a[k] <= a_vec[(MAX_NNZ-1-k)*IDX_W +: IDX_W];
                idx_b[k] <= b_vec[(MAX_NNZ-1-k)*IDX_W +: IDX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_i   <= '0;
            col_j   <= '0;
            pa      <= '0;
            pb      <= '0;
            nnz_a   <= '0;
            nnz_b   <= '0;
            acc     <= '0;
            acc_v   <= 1'b0;
            nnz_err <= 1'b0;
            fpu_op  <= 1'b0;
            fpu_a   <= '0;
            fpu_b   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row_i   <= '0;
                        col_j   <= '0;
                        nnz_err <= 1'b0;
                    end
                end
                LOAD: begin
                    pa      <= '0;
                    pb      <= '0;
                    acc_v   <= 1'b0;
                    nnz_a   <= clamp_nnz(a_vec[VEC_W-1 -: 7]);
                    nnz_b   <= clamp_nnz(b_vec[VEC_W-1 -: 7]);
                    nnz_err <= nnz_err | over_nnz(a_vec[VEC_W-1 -: 7])
                                       | over_nnz(b_vec[VEC_W-1 -: 7]);
                end
                CMP: begin
                    if (!end_cmp) begin
                        if (hit) begin
                            pa     <= pa + PTR_W'(1);
                            pb     <= pb + PTR_W'(1);
                            fpu_op <= 1'b0;
                            fpu_a  <= val_a[sel_a];
                            fpu_b  <= val_b[sel_b];
                        end else if (cur_idx_a < cur_idx_b) begin
                            pa <= pa + PTR_W'(1);
                        end else begin
                            pb <= pb + PTR_W'(1);
                        end
                    end
                end
                MUL_WAIT: begin
                    if (fpu_complete) begin
                        if (!acc_v) begin
                            acc   <= fpu_result;
                            acc_v <= 1'b1;
                        end else begin
                            // Product goes straight into the ADD operand slot.
                            fpu_op <= 1'b1;
                            fpu_a  <= acc;
                            fpu_b  <= fpu_result;
                        end
                    end
                end
                ADD_WAIT: if (fpu_complete) acc <= fpu_result;
                EMIT: begin
                    if (col_j == LAST) begin
                        col_j <= '0;
                        row_i <= row_i + VEC_AW'(1);
                    end else begin
                        col_j <= col_j + VEC_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
